// File: rtl/commit_skew_checker.sv
// commit_skew_checker: aligns two cpu copies' commit streams through a skew FIFO and flags
// commit/address deviations, secret-touching load pairs, ROB drain and induction windows.
module commit_skew_checker #(
  parameter int ROB_SIZE_LOG  = 3,
  parameter int MEMD_SIZE_LOG = 2,
  parameter int SECRET_ADDR   = 1,
  parameter int SKEW_DEPTH    = 4,
  parameter int OBSV_MODE     = 0,
  parameter int INDUCTION_K   = 20,
  parameter int LOOK_AHEAD    = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              c1_valid,
  input  logic                              c1_mem_valid,
  input  logic                              c1_mem_rdwt,
  input  logic [MEMD_SIZE_LOG-1:0]          c1_mem_addr,
  input  logic                              c1_squash,
  input  logic [ROB_SIZE_LOG-1:0]           c1_rob_head,
  input  logic [ROB_SIZE_LOG-1:0]           c1_rob_tail,
  input  logic [MEMD_SIZE_LOG-1:0]          c1_ld_addr,
  input  logic                              c2_valid,
  input  logic                              c2_mem_valid,
  input  logic                              c2_mem_rdwt,
  input  logic [MEMD_SIZE_LOG-1:0]          c2_mem_addr,
  input  logic                              c2_squash,
  input  logic [ROB_SIZE_LOG-1:0]           c2_rob_head,
  input  logic [ROB_SIZE_LOG-1:0]           c2_rob_tail,
  input  logic [MEMD_SIZE_LOG-1:0]          c2_ld_addr,
  input  logic                              invariants_ok,
  output logic                              stall_1,
  output logic                              stall_2,
  output logic                              commit_deviation,
  output logic                              addr_deviation,
  output logic                              invalid_program,
  output logic                              finish_1,
  output logic                              finish_2,
  output logic [$clog2(SKEW_DEPTH):0]       skew_count,
  output logic                              assume_ok,
  output logic                              assert_ok
);
  localparam int CW = $clog2(SKEW_DEPTH) + 1;
  localparam int PW = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;
  localparam int MW = MEMD_SIZE_LOG;
  localparam int RW = MW + 2;
  localparam int NW = $clog2(INDUCTION_K + LOOK_AHEAD + 2);
  localparam logic [MW-1:0] SA = MW'(SECRET_ADDR);
  typedef enum logic [1:0] {LEAD_NONE, LEAD_1, LEAD_2} lead_e;

  logic [RW-1:0]           fifo_q [SKEW_DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  lead_e                   lead_q, lead_d;
  logic                    cd_q, cd_d, ad_q, ad_d, inv_q, inv_d, f1_q, f1_d, f2_q, f2_d;
  logic [ROB_SIZE_LOG-1:0] tail1_q, tail1_d, tail2_q, tail2_d;
  logic [NW-1:0]           ctr_q, ctr_d;
  logic [LOOK_AHEAD:1]     ak_q, ak_d, an_q, an_d;
  logic [LOOK_AHEAD:0]     ak_w, an_w;
  logic                    e1, e2, empty, lead1, push, pop, dev_q, dev, ak0, an0;
  logic [RW-1:0]           rec1, rec2, pa, pb, push_rec;

  function automatic logic bad_pair(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a[RW-1] & a[RW-2] & b[RW-1] & b[RW-2] & ((a[MW-1:0] == SA) | (b[MW-1:0] == SA));
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(SKEW_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty    = (cnt_q == '0);
    lead1    = (lead_q == LEAD_1);
    stall_1  = (cnt_q == CW'(SKEW_DEPTH)) & lead1;
    stall_2  = (cnt_q == CW'(SKEW_DEPTH)) & (lead_q == LEAD_2);
    e1       = c1_valid & ~stall_1;
    e2       = c2_valid & ~stall_2;
    rec1     = {c1_mem_valid, c1_mem_rdwt, c1_mem_addr};
    rec2     = {c2_mem_valid, c2_mem_rdwt, c2_mem_addr};
    push     = empty ? (e1 ^ e2) : (lead1 ? e1 : e2);
    pop      = ~empty & (lead1 ? e2 : e1);
    push_rec = (empty ? e1 : lead1) ? rec1 : rec2;
    // Live pair when aligned; otherwise the oldest lead record meets the lag's live one.
    pa       = empty ? rec1 : fifo_q[rd_q];
    pb       = (empty | lead1) ? rec2 : rec1;
    wr_d     = push ? nxt(wr_q) : wr_q;
    rd_d     = pop ? nxt(rd_q) : rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    lead_d   = (cnt_d == '0) ? LEAD_NONE : (empty & push) ? (e1 ? LEAD_1 : LEAD_2) : lead_q;
    inv_d    = inv_q | ((empty ? (e1 & e2) : pop) & bad_pair(pa, pb));
    cd_d     = cd_q | (empty & (e1 ^ e2));
    ad_d     = (OBSV_MODE != 0) & (ad_q | (~cd_q & (c1_ld_addr != c2_ld_addr)));
    dev_q    = cd_q | ad_q;
    tail1_d  = (~dev_q & (cd_d | ad_d)) ? c1_rob_tail : tail1_q;
    tail2_d  = (~dev_q & (cd_d | ad_d)) ? c2_rob_tail : tail2_q;
    f1_d     = f1_q | (dev_q & e1 & ((c1_rob_head == ROB_SIZE_LOG'(tail1_q - 1'b1)) | c1_squash));
    f2_d     = f2_q | (dev_q & e2 & ((c2_rob_head == ROB_SIZE_LOG'(tail2_q - 1'b1)) | c2_squash));
    ctr_d    = (ctr_q == NW'(INDUCTION_K + LOOK_AHEAD + 1)) ? ctr_q : ctr_q + 1'b1;
    dev      = cd_q | ad_q | ~invariants_ok;
    ak0      = ~((ctr_q < NW'(INDUCTION_K)) & dev);
    an0      = ~((ctr_q == NW'(INDUCTION_K)) & dev);
    ak_w     = {ak_q, ak0};
    an_w     = {an_q, an0};
    ak_d     = ak_w[LOOK_AHEAD-1:0];
    an_d     = an_w[LOOK_AHEAD-1:0];
  end

  always_ff @(posedge clk)
    if (push) fifo_q[wr_q] <= push_rec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      lead_q  <= LEAD_NONE;
      cd_q    <= 1'b0;
      ad_q    <= 1'b0;
      inv_q   <= 1'b0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      tail1_q <= '0;
      tail2_q <= '0;
      ctr_q   <= '0;
      ak_q    <= '1;
      an_q    <= '1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      lead_q  <= lead_d;
      cd_q    <= cd_d;
      ad_q    <= ad_d;
      inv_q   <= inv_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      tail1_q <= tail1_d;
      tail2_q <= tail2_d;
      ctr_q   <= ctr_d;
      ak_q    <= ak_d;
      an_q    <= an_d;
    end
  end

  assign commit_deviation = cd_q;
  assign addr_deviation   = ad_q;
  assign invalid_program  = inv_q;
  assign finish_1         = f1_q;
  assign finish_2         = f2_q;
  assign skew_count       = cnt_q;
  assign assume_ok        = ak_q[LOOK_AHEAD];
  assign assert_ok        = an_q[LOOK_AHEAD];
endmodule
